// File: rtl/link_sync_pkg.sv
// Shared types and constants for the link synchronisation controller.
package link_sync_pkg;

  localparam int unsigned WORD_W = 9;

  // K28.5 comma: bit 8 is the K flag, bits 7:0 are the 8b symbol.
  localparam logic [WORD_W-1:0] K28_5 = 9'h1BC;

  typedef enum logic [1:0] {
    LOS   = 2'd0,
    ACQ   = 2'd1,
    SYNC  = 2'd2,
    CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/link_sync_satcnt.sv
// Parameterised-width saturating up-counter used for link statistics.
module link_sync_satcnt
  import link_sync_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count increment requests, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/link_sync_ctrl.sv
// Word-alignment / loss-of-sync controller for an 8b10b receive path.
// Optional statistics counters enabled by defining LINK_SYNC_STATS_EN.
module link_sync_ctrl
  import link_sync_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA     = K28_5,
  parameter int unsigned       COMMA_CNT = 3,
  parameter int unsigned       SLIP_TMO  = 20,
  parameter int unsigned       SLIP_WAIT = 2,
  parameter int unsigned       ERR_MAX   = 4,
  parameter int unsigned       GOOD_CNT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_vld_i,
  input  logic              word_err_i,
  input  logic              force_resync_i,
  output logic              bitslip_o,
  output logic              sync_o,
  output logic [1:0]        state_o,
  output logic [2:0]        err_cnt_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o,
  output logic [15:0]       loss_cnt_o,
  output logic [15:0]       slip_cnt_o
);

  localparam int unsigned MISS_W  = $clog2(SLIP_TMO + 1);
  localparam int unsigned BLANK_W = $clog2(SLIP_WAIT + 1);
  localparam int unsigned COMMA_W = $clog2(COMMA_CNT + 1);
  localparam int unsigned ERR_W   = $clog2(ERR_MAX + 1);
  localparam int unsigned GOOD_W  = $clog2(GOOD_CNT + 1);

  state_t               state;
  logic [MISS_W-1:0]    miss_cnt;
  logic [BLANK_W-1:0]   blank_cnt;
  logic [COMMA_W-1:0]   comma_cnt;
  logic [ERR_W-1:0]     err_cnt;
  logic [GOOD_W-1:0]    good_cnt;
  logic                 is_comma;

  assign is_comma  = (word_i == COMMA);
  assign state_o   = state;
  assign sync_o    = (state == SYNC) || (state == CHECK);
  assign err_cnt_o = 3'(err_cnt);

  // Sync FSM, its counters and the registered bitslip/forwarding outputs.
  // Forwarding is decided per branch from the state being entered, so a
  // word that completes acquisition is forwarded and one that drops to LOS
  // is not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= LOS;
      miss_cnt   <= '0;
      blank_cnt  <= '0;
      comma_cnt  <= '0;
      err_cnt    <= '0;
      good_cnt   <= '0;
      bitslip_o  <= 1'b0;
      word_vld_o <= 1'b0;
      word_o     <= '0;
    end else begin
      bitslip_o  <= 1'b0;
      word_vld_o <= 1'b0;
      if (force_resync_i) begin
        state     <= LOS;
        miss_cnt  <= '0;
        blank_cnt <= '0;
        comma_cnt <= '0;
        err_cnt   <= '0;
        good_cnt  <= '0;
      end else if (word_vld_i) begin
        case (state)
          LOS: begin
            if (blank_cnt != '0) begin
              blank_cnt <= blank_cnt - 1'b1;
            end else if (is_comma && !word_err_i) begin
              state     <= ACQ;
              comma_cnt <= COMMA_W'(1);
              miss_cnt  <= '0;
            end else if (miss_cnt == MISS_W'(SLIP_TMO - 1)) begin
              bitslip_o <= 1'b1;
              miss_cnt  <= '0;
              blank_cnt <= BLANK_W'(SLIP_WAIT);
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          ACQ: begin
            if (word_err_i) begin
              state     <= LOS;
              miss_cnt  <= '0;
              comma_cnt <= '0;
            end else if (is_comma) begin
              if (comma_cnt == COMMA_W'(COMMA_CNT - 1)) begin
                state      <= SYNC;
                comma_cnt  <= '0;
                word_vld_o <= 1'b1;
                word_o     <= word_i;
              end else begin
                comma_cnt <= comma_cnt + 1'b1;
              end
            end
          end
          SYNC: begin
            word_vld_o <= 1'b1;
            word_o     <= word_i;
            if (word_err_i) begin
              state    <= CHECK;
              err_cnt  <= ERR_W'(1);
              good_cnt <= '0;
            end
          end
          CHECK: begin
            if (word_err_i) begin
              good_cnt <= '0;
              if (err_cnt == ERR_W'(ERR_MAX - 1)) begin
                state    <= LOS;
                err_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                err_cnt    <= err_cnt + 1'b1;
                word_vld_o <= 1'b1;
                word_o     <= word_i;
              end
            end else begin
              word_vld_o <= 1'b1;
              word_o     <= word_i;
              if (good_cnt == GOOD_W'(GOOD_CNT - 1)) begin
                good_cnt <= '0;
                err_cnt  <= err_cnt - 1'b1;
                if (err_cnt == ERR_W'(1)) begin
                  state <= SYNC;
                end
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
          end
          default: state <= LOS;
        endcase
      end
    end
  end

`ifdef LINK_SYNC_STATS_EN
  logic sync_d;
  logic loss_inc;

  // Every exit from SYNC/CHECK lands in LOS, so a falling sync_o marks a
  // loss event; counters therefore lag the state change by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_d <= 1'b0;
    end else begin
      sync_d <= sync_o;
    end
  end

  assign loss_inc = sync_d & ~sync_o;

  link_sync_satcnt #(.WIDTH(16)) u_loss_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (loss_inc),
    .count (loss_cnt_o)
  );

  link_sync_satcnt #(.WIDTH(16)) u_slip_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (bitslip_o),
    .count (slip_cnt_o)
  );
`else
  assign loss_cnt_o = '0;
  assign slip_cnt_o = '0;
`endif

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed self-checking bench for link_sync_ctrl.
module tb_link_sync_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [8:0]  word_i = '0;
  logic        word_vld_i = 1'b0;
  logic        word_err_i = 1'b0;
  logic        force_resync_i = 1'b0;
  logic        bitslip_o;
  logic        sync_o;
  logic [1:0]  state_o;
  logic [2:0]  err_cnt_o;
  logic [8:0]  word_o;
  logic        word_vld_o;
  logic [15:0] loss_cnt_o;
  logic [15:0] slip_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [8:0] K = 9'h1BC;
  localparam logic [8:0] D = 9'h055;

  link_sync_ctrl #(
    .COMMA(9'h1BC), .COMMA_CNT(3), .SLIP_TMO(20),
    .SLIP_WAIT(2), .ERR_MAX(4), .GOOD_CNT(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .word_i(word_i), .word_vld_i(word_vld_i),
    .word_err_i(word_err_i), .force_resync_i(force_resync_i),
    .bitslip_o(bitslip_o), .sync_o(sync_o), .state_o(state_o),
    .err_cnt_o(err_cnt_o), .word_o(word_o), .word_vld_o(word_vld_o),
    .loss_cnt_o(loss_cnt_o), .slip_cnt_o(slip_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic send(input logic [8:0] w, input logic e);
    word_i = w; word_err_i = e; word_vld_i = 1'b1;
    @(posedge clk_i); #1;
    word_vld_i = 1'b0; word_err_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
  endtask

  function automatic logic [15:0] stat_exp(input logic [15:0] n);
`ifdef LINK_SYNC_STATS_EN
    return n;
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset;
    rst_ni = 1'b0;
    idle(2);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_o); end
    checks++; if ({bitslip_o, sync_o, word_vld_o} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {bitslip_o, sync_o, word_vld_o}); end
    checks++; if (err_cnt_o !== 3'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", err_cnt_o); end
    checks++; if (word_o !== 9'h000) begin errors++; $display("FAIL rst_word got %h exp 000", word_o); end
    checks++; if ({loss_cnt_o, slip_cnt_o} !== 32'd0) begin errors++; $display("FAIL rst_stats got %h exp 0", {loss_cnt_o, slip_cnt_o}); end
    rst_ni = 1'b1;
    idle(1);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_idle_state got %0d exp 0", state_o); end
  endtask

  task automatic test_acquire;
    send(K, 1'b0);
    checks++; if (state_o !== 2'd1 || word_vld_o !== 1'b0) begin errors++; $display("FAIL acq1 got st=%0d vld=%b exp st=1 vld=0", state_o, word_vld_o); end
    send(K, 1'b0);
    checks++; if (state_o !== 2'd1 || sync_o !== 1'b0 || word_vld_o !== 1'b0) begin errors++; $display("FAIL acq2 got st=%0d sync=%b vld=%b exp 1/0/0", state_o, sync_o, word_vld_o); end
    send(K, 1'b0);
    checks++; if (state_o !== 2'd2 || sync_o !== 1'b1) begin errors++; $display("FAIL acq3 got st=%0d sync=%b exp st=2 sync=1", state_o, sync_o); end
    checks++; if (word_vld_o !== 1'b1 || word_o !== K) begin errors++; $display("FAIL acq3_fwd got vld=%b w=%h exp vld=1 w=1bc", word_vld_o, word_o); end
    idle(1);
    checks++; if (word_vld_o !== 1'b0 || sync_o !== 1'b1) begin errors++; $display("FAIL acq_idle got vld=%b sync=%b exp 0/1", word_vld_o, sync_o); end
    send(9'h0A5, 1'b0);
    checks++; if (word_vld_o !== 1'b1 || word_o !== 9'h0A5 || state_o !== 2'd2) begin errors++; $display("FAIL sync_data got vld=%b w=%h st=%0d exp 1/0a5/2", word_vld_o, word_o, state_o); end
  endtask

  task automatic test_err_drop;
    for (int i = 1; i <= 3; i++) begin
      send(9'h0FF, 1'b1);
      checks++; if (err_cnt_o !== 3'(i) || state_o !== 2'd3 || sync_o !== 1'b1 || word_vld_o !== 1'b1) begin
        errors++; $display("FAIL drop_err%0d got err=%0d st=%0d sync=%b vld=%b exp err=%0d st=3 sync=1 vld=1", i, err_cnt_o, state_o, sync_o, word_vld_o, i);
      end
    end
    send(9'h0FF, 1'b1);
    checks++; if (state_o !== 2'd0 || sync_o !== 1'b0 || err_cnt_o !== 3'd0 || word_vld_o !== 1'b0) begin
      errors++; $display("FAIL drop_los got st=%0d sync=%b err=%0d vld=%b exp 0/0/0/0", state_o, sync_o, err_cnt_o, word_vld_o);
    end
    idle(1);
    checks++; if (loss_cnt_o !== stat_exp(16'd1)) begin errors++; $display("FAIL drop_loss_cnt got %0d exp %0d", loss_cnt_o, stat_exp(16'd1)); end
  endtask

  task automatic test_check_recover;
    repeat (3) send(K, 1'b0);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL rec_sync got %0d exp 2", state_o); end
    send(9'h0FF, 1'b1);
    repeat (3) send(D, 1'b0);
    checks++; if (state_o !== 2'd3 || err_cnt_o !== 3'd1) begin errors++; $display("FAIL rec_3good got st=%0d err=%0d exp 3/1", state_o, err_cnt_o); end
    send(D, 1'b0);
    checks++; if (state_o !== 2'd2 || err_cnt_o !== 3'd0) begin errors++; $display("FAIL rec_4good got st=%0d err=%0d exp 2/0", state_o, err_cnt_o); end
    // error on good word 3 restarts the good run
    send(9'h0FF, 1'b1);
    send(D, 1'b0); send(D, 1'b0);
    send(9'h0FF, 1'b1);
    checks++; if (state_o !== 2'd3 || err_cnt_o !== 3'd2) begin errors++; $display("FAIL rec_err3 got st=%0d err=%0d exp 3/2", state_o, err_cnt_o); end
    repeat (3) send(D, 1'b0);
    checks++; if (err_cnt_o !== 3'd2) begin errors++; $display("FAIL rec_goodrst got err=%0d exp 2", err_cnt_o); end
    send(D, 1'b0);
    checks++; if (err_cnt_o !== 3'd1 || state_o !== 2'd3) begin errors++; $display("FAIL rec_dec got err=%0d st=%0d exp 1/3", err_cnt_o, state_o); end
    repeat (4) send(D, 1'b0);
    checks++; if (err_cnt_o !== 3'd0 || state_o !== 2'd2) begin errors++; $display("FAIL rec_back got err=%0d st=%0d exp 0/2", err_cnt_o, state_o); end
  endtask

  task automatic test_force;
    force_resync_i = 1'b1;
    send(K, 1'b0);
    force_resync_i = 1'b0;
    checks++; if (state_o !== 2'd0 || word_vld_o !== 1'b0 || sync_o !== 1'b0 || err_cnt_o !== 3'd0) begin
      errors++; $display("FAIL force got st=%0d vld=%b sync=%b err=%0d exp 0/0/0/0", state_o, word_vld_o, sync_o, err_cnt_o);
    end
    idle(1);
    checks++; if (loss_cnt_o !== stat_exp(16'd2)) begin errors++; $display("FAIL force_loss_cnt got %0d exp %0d", loss_cnt_o, stat_exp(16'd2)); end
  endtask

  task automatic test_reset_mid_acq;
    send(K, 1'b0); send(K, 1'b0);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL mid_acq got %0d exp 1", state_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (state_o !== 2'd0 || bitslip_o !== 1'b0) begin errors++; $display("FAIL mid_rst got st=%0d slip=%b exp 0/0", state_o, bitslip_o); end
    idle(1);
    rst_ni = 1'b1;
    send(K, 1'b0); send(K, 1'b0);
    checks++; if (state_o !== 2'd1 || sync_o !== 1'b0) begin errors++; $display("FAIL mid_2c got st=%0d sync=%b exp 1/0", state_o, sync_o); end
    send(K, 1'b0);
    checks++; if (state_o !== 2'd2 || sync_o !== 1'b1) begin errors++; $display("FAIL mid_3c got st=%0d sync=%b exp 2/1", state_o, sync_o); end
  endtask

  task automatic test_bitslip;
    logic seen;
    force_resync_i = 1'b1; idle(1); force_resync_i = 1'b0;
    repeat (10) send(D, 1'b0);
    force_resync_i = 1'b1; idle(1); force_resync_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin send(D, 1'b0); seen |= bitslip_o; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL slip_early got %b exp 0", seen); end
    send(D, 1'b0);
    checks++; if (bitslip_o !== 1'b1) begin errors++; $display("FAIL slip_20 got %b exp 1", bitslip_o); end
    idle(1);
    checks++; if (bitslip_o !== 1'b0) begin errors++; $display("FAIL slip_pulse got %b exp 0", bitslip_o); end
    send(K, 1'b0); send(K, 1'b0);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL slip_blank got %0d exp 0", state_o); end
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin send(D, 1'b0); seen |= bitslip_o; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL slip_recount got %b exp 0", seen); end
    send(D, 1'b0);
    checks++; if (bitslip_o !== 1'b1) begin errors++; $display("FAIL slip_2nd got %b exp 1", bitslip_o); end
    idle(1);
    checks++; if (slip_cnt_o !== stat_exp(16'd2) || loss_cnt_o !== stat_exp(16'd1)) begin
      errors++; $display("FAIL slip_stats got slip=%0d loss=%0d exp %0d/%0d", slip_cnt_o, loss_cnt_o, stat_exp(16'd2), stat_exp(16'd1));
    end
  endtask

  task automatic test_reset_clears_blank;
    send(D, 1'b0);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL blank_pre got %0d exp 0", state_o); end
    rst_ni = 1'b0; idle(1); rst_ni = 1'b1;
    send(K, 1'b0);
    checks++; if (state_o !== 2'd1 || bitslip_o !== 1'b0) begin errors++; $display("FAIL blank_rst got st=%0d slip=%b exp 1/0", state_o, bitslip_o); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_err_drop();
    test_check_recover();
    test_force();
    test_reset_mid_acq();
    test_bitslip();
    test_reset_clears_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_sync_ctrl.md
LINK_SYNC_CTRL -- requirements
Module: link_sync_ctrl

Interface
REQ-001 Parameter COMMA, default 9'h1BC (K28.5, bit 8 = K flag); comma code word.
REQ-002 Parameter COMMA_CNT, default 3; consecutive clean commas needed to reach sync.
REQ-003 Parameter SLIP_TMO, default 20; valid words without a comma in LOS before a bitslip.
REQ-004 Parameter SLIP_WAIT, default 2; valid words ignored after a bitslip.
REQ-005 Parameter ERR_MAX, default 4; error count that drops sync.
REQ-006 Parameter GOOD_CNT, default 4; consecutive good words that decrement the error count.
REQ-007 clk_i  in  1  clock; all logic on posedge.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 word_i  in  9  decoded word {K, data[7:0]} from the deserializer.
REQ-010 word_vld_i  in  1  one-cycle strobe; word_i and word_err_i valid.
REQ-011 word_err_i  in  1  code or disparity error on the current word.
REQ-012 force_resync_i  in  1  synchronous request to drop to LOS.
REQ-013 bitslip_o  out  1  one-cycle pulse; deserializer shifts its word boundary by one bit.
REQ-014 sync_o  out  1  link synchronized (state SYNC or CHECK).
REQ-015 state_o  out  2  current FSM state encoding.
REQ-016 err_cnt_o  out  3  current error count.
REQ-017 word_o / word_vld_o  out  9 / 1  forwarded payload and strobe.
REQ-018 loss_cnt_o / slip_cnt_o  out  16 / 16  statistics counters (see Configuration).

Function
REQ-019 FSM states SHALL be LOS=0, ACQ=1, SYNC=2, CHECK=3; transitions are evaluated only on cycles with word_vld_i=1, except force_resync_i.
REQ-020 LOS: comma with no error -> ACQ, comma count=1; any other word -> miss count+1; miss count reaching SLIP_TMO -> bitslip_o pulse, miss count=0, blank count=SLIP_WAIT.
REQ-021 While blank count>0, each valid word SHALL only decrement the blank count, with no comma or miss evaluation.
REQ-022 ACQ: error word -> LOS, miss count=0; clean comma -> comma count+1, reaching COMMA_CNT -> SYNC; clean non-comma -> stay, count held.
REQ-023 SYNC: error word -> CHECK, err count=1, good count=0; clean word -> stay.
REQ-024 CHECK: error word -> err count+1, good count=0, reaching ERR_MAX -> LOS; clean word -> good count+1, reaching GOOD_CNT -> err count-1, good count=0, err count reaching 0 -> SYNC.
REQ-025 force_resync_i=1 SHALL force next state LOS and clear all counters, with priority over a simultaneous word_vld_i; the word is not forwarded.
REQ-026 Outputs SHALL be registered, updating the cycle after the evaluating word_vld_i edge.
REQ-027 word_vld_o SHALL equal word_vld_i delayed one cycle, gated by next state being SYNC or CHECK; the word that completes acquisition is forwarded and the word that causes LOS is not.
REQ-028 All internal counters SHALL be sized to their parameter and SHALL never wrap.

Reset
REQ-029 rst_ni low SHALL set state LOS, clear all counters and blank count, and drive bitslip_o, sync_o, word_vld_o, err_cnt_o, loss_cnt_o and slip_cnt_o to 0 and word_o to 9'h000.
REQ-030 Reset asserted mid-acquisition or mid-CHECK SHALL abort immediately; there is no pending bitslip after release.

Configuration
REQ-031 With macro LINK_SYNC_STATS_EN defined, loss_cnt_o SHALL count each entry to LOS from SYNC or CHECK, and slip_cnt_o SHALL count bitslip_o pulses; both are 16-bit and saturate at 16'hFFFF.
REQ-032 Without LINK_SYNC_STATS_EN, loss_cnt_o and slip_cnt_o SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-033 Package link_sync_pkg SHALL hold the state enum, the K28_5 constant (9'h1BC) and the word-width localparam.
REQ-034 Sub-module link_sync_satcnt (parameterized-width saturating counter) SHALL implement both statistics counters.

Verification
REQ-035 After reset, 3 clean 9'h1BC words -> sync_o=1 one cycle after the third; word_vld_o pulses for the third word only.
REQ-036 In LOS, 20 valid 9'h055 words -> one bitslip_o pulse; the next 2 valid words are ignored; the 21st miss-counted word starts a new count.
REQ-037 In SYNC, 4 error words -> err_cnt_o goes 1,2,3, then LOS with sync_o=0; loss_cnt_o=1 with LINK_SYNC_STATS_EN.
REQ-038 In CHECK with err count 1, 4 clean words -> err_cnt_o=0, state SYNC; an error on good word 3 resets the good count.
REQ-039 force_resync_i together with word_vld_i carrying a comma in SYNC -> LOS, word_vld_o=0, all counters 0.
REQ-040 rst_ni pulsed low during ACQ after 2 commas -> state LOS; 3 further commas are needed to reach sync.
